// File: rtl/cam_boot_seq.sv
// Camera boot sequencer: lock wait, power-up delay, stretched start pulse, done wait with retry.
// Optional CAM_AUTOBOOT_EN: leave IDLE straight after reset without waiting for a press.
module cam_boot_seq #(
    parameter int unsigned DEBOUNCE_CYC    = 240_000,
    parameter int unsigned PWRUP_CYC       = 1_000_000,
    parameter int unsigned START_PULSE_CYC = 8,
    parameter int unsigned TIMEOUT_CYC     = 50_000_000,
    parameter int unsigned MAX_RETRY       = 3
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_btn_start,
    input  logic       i_locked,
    input  logic       i_cam_done,
    output logic       o_cam_start,
    output logic       o_busy,
    output logic       o_ready,
    output logic       o_fault,
    output logic [1:0] o_retry_cnt,
    output logic [2:0] o_state
);

    localparam int unsigned Max1   = (PWRUP_CYC > TIMEOUT_CYC) ? PWRUP_CYC : TIMEOUT_CYC;
    localparam int unsigned CntMax = (Max1 > START_PULSE_CYC) ? Max1 : START_PULSE_CYC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned DbW    = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [CntW-1:0] PwrupLoad   = CntW'(PWRUP_CYC - 1);
    localparam logic [CntW-1:0] PulseLoad   = CntW'(START_PULSE_CYC - 1);
    localparam logic [CntW-1:0] TimeoutLoad = CntW'(TIMEOUT_CYC - 1);
    localparam logic [DbW-1:0]  DbLast      = DbW'(DEBOUNCE_CYC - 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWaitLock = 3'd1,
        StPwrup    = 3'd2,
        StStart    = 3'd3,
        StWaitDone = 3'd4,
        StReady    = 3'd5,
        StFault    = 3'd6
    } state_e;

    logic [1:0]     btn_sync_q, lock_sync_q, done_sync_q;
    logic           btn_s, lock_s, done_s;
    logic [DbW-1:0] db_cnt_q;
    logic           db_q, press_q;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      retry_q, retry_d;
    logic            seen_low_q, seen_low_d;
    logic            lock_lost;
    logic            start_q, busy_q, ready_q, fault_q;

    assign btn_s  = btn_sync_q[1];
    assign lock_s = lock_sync_q[1];
    assign done_s = done_sync_q[1];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            btn_sync_q  <= '0;
            lock_sync_q <= '0;
            done_sync_q <= '0;
            db_cnt_q    <= '0;
            db_q        <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            btn_sync_q  <= {btn_sync_q[0], i_btn_start};
            lock_sync_q <= {lock_sync_q[0], i_locked};
            done_sync_q <= {done_sync_q[0], i_cam_done};
            press_q     <= 1'b0;
            // Level must differ from the accepted value for DEBOUNCE_CYC straight cycles.
            if (btn_s == db_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DbLast) begin
                db_cnt_q <= '0;
                db_q     <= btn_s;
                press_q  <= btn_s;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        seen_low_d = seen_low_q;
        cnt_d      = cnt_q;
        lock_lost  = !lock_s && (state_q inside {StPwrup, StStart, StWaitDone, StReady});

        case (state_q)
            StIdle: begin
`ifdef CAM_AUTOBOOT_EN
                state_d = StWaitLock;
`else
                if (press_q) state_d = StWaitLock;
`endif
            end
            StWaitLock: if (lock_s) state_d = StPwrup;
            StPwrup:    if (cnt_q == '0) state_d = StStart;
            StStart:    if (cnt_q == '0) state_d = StWaitDone;
            StWaitDone: begin
                if (done_s && seen_low_q) begin
                    state_d = StReady;
                end else if (cnt_q == '0) begin
                    if (retry_q != 2'd3) retry_d = retry_q + 2'd1;
                    state_d = (32'(retry_q) < MAX_RETRY) ? StPwrup : StFault;
                end
            end
            StReady: if (press_q) begin
                state_d = StStart;
                retry_d = '0;
            end
            StFault: if (press_q) begin
                state_d = StWaitLock;
                retry_d = '0;
            end
            default: state_d = StIdle;
        endcase

        if (lock_lost) begin
            state_d = StWaitLock;
            retry_d = retry_q;
        end

        // One shared down-counter, reloaded on every state entry.
        if (state_d != state_q) begin
            case (state_d)
                StPwrup:    cnt_d = PwrupLoad;
                StStart:    cnt_d = PulseLoad;
                StWaitDone: cnt_d = TimeoutLoad;
                default:    cnt_d = '0;
            endcase
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end

        // A done level left over from a previous boot must not count as completion.
        if (state_d == StStart && state_q != StStart) begin
            seen_low_d = 1'b0;
        end else if ((state_q == StStart || state_q == StWaitDone) && !done_s) begin
            seen_low_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            retry_q    <= '0;
            seen_low_q <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            seen_low_q <= seen_low_d;
            start_q    <= (state_d == StStart);
            busy_q     <= (state_d inside {StWaitLock, StPwrup, StStart, StWaitDone});
            ready_q    <= (state_d == StReady);
            fault_q    <= (state_d == StFault);
        end
    end

    assign o_cam_start = start_q;
    assign o_busy      = busy_q;
    assign o_ready     = ready_q;
    assign o_fault     = fault_q;
    assign o_retry_cnt = retry_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_cam_boot_seq.sv
// Bench for cam_boot_seq (default build): start pulses are scored against a queue of expected widths.
module tb_cam_boot_seq;

    logic       clk = 1'b0;
    logic       rstn, btn, locked, done;
    logic       cam_start, busy, ready, fault;
    logic [1:0] retry_cnt;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int pw = 0;

    localparam logic [2:0] SIdle = 3'd0, SWaitLock = 3'd1, SPwrup = 3'd2, SStart = 3'd3;
    localparam logic [2:0] SWaitDone = 3'd4, SReady = 3'd5, SFault = 3'd6;

    cam_boot_seq #(
        .DEBOUNCE_CYC   (10),
        .PWRUP_CYC      (20),
        .START_PULSE_CYC(8),
        .TIMEOUT_CYC    (100),
        .MAX_RETRY      (2)
    ) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_btn_start(btn),
        .i_locked   (locked),
        .i_cam_done (done),
        .o_cam_start(cam_start),
        .o_busy     (busy),
        .o_ready    (ready),
        .o_fault    (fault),
        .o_retry_cnt(retry_cnt),
        .o_state    (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, state, s);
    endtask

    task automatic count_while(input logic [2:0] s, output int n);
        n = 0;
        while (state === s && n < 1000) begin
            tick(1);
            n++;
        end
    endtask

    task automatic press_bg();
        fork
            begin
                btn = 1'b1;
                tick(15);
                btn = 1'b0;
            end
        join_none
    endtask

    // Pulse monitor: width of every o_cam_start pulse is compared against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (cam_start === 1'b1) begin
                pw++;
            end else if (pw > 0) begin
                if (exp_q.size() == 0) check("pulse_unexpected", pw, 0);
                else check("pulse_width", pw, exp_q.pop_front());
                pw = 0;
            end
        end
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rstn = 1'b0;
        btn = 1'b0;
        locked = 1'b1;
        done = 1'b0;
        tick(3);
        check("rst_start", cam_start, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 0);
        check("rst_fault", fault, 0);
        check("rst_retry", retry_cnt, 0);
        check("rst_state", state, SIdle);
        rstn = 1'b1;
        tick(20);
        check("idle_no_press", state, SIdle);

        // Bounce: never stable long enough to register.
        for (int i = 0; i < 10; i++) begin
            btn = ~btn;
            tick(5);
        end
        btn = 1'b0;
        tick(30);
        check("bounce_idle", state, SIdle);

        // Nominal boot.
        exp_q.push_back(8);
        press_bg();
        wait_state(SPwrup, 40, "nom_pwrup");
        count_while(SPwrup, n);
        check("nom_pwrup_len", n, 20);
        check("nom_start_state", state, SStart);
        check("nom_start_hi", cam_start, 1);
        wait_state(SWaitDone, 20, "nom_waitdone");
        tick(40);
        done = 1'b1;
        n = 0;
        while (!ready && n < 20) begin
            tick(1);
            n++;
        end
        check("nom_ready_lat", n, 3);
        check("nom_state", state, SReady);
        check("nom_retry", retry_cnt, 0);
        check("nom_busy", busy, 0);

        // Stale done: done still high from the previous boot.
        exp_q.push_back(8);
        press_bg();
        wait_state(SStart, 40, "stale_start");
        wait_state(SWaitDone, 20, "stale_waitdone");
        tick(30);
        check("stale_hold", state, SWaitDone);
        done = 1'b0;
        tick(5);
        done = 1'b1;
        n = 0;
        while (!ready && n < 20) begin
            tick(1);
            n++;
        end
        check("stale_ready_lat", n, 3);

        // Lock loss during the third pulse cycle.
        done = 1'b0;
        exp_q.push_back(5);
        press_bg();
        n = 0;
        while (!cam_start && n < 40) begin
            tick(1);
            n++;
        end
        check("ll_pulse_seen", cam_start, 1);
        tick(2);
        locked = 1'b0;
        n = 0;
        while (cam_start && n < 10) begin
            tick(1);
            n++;
        end
        check("ll_drop_within_3", (n <= 3), 1);
        check("ll_state", state, SWaitLock);
        check("ll_retry", retry_cnt, 0);
        tick(5);
        check("ll_hold", state, SWaitLock);
        exp_q.push_back(8);
        locked = 1'b1;
        wait_state(SPwrup, 10, "ll_relock");
        count_while(SPwrup, n);
        check("ll_pwrup_len", n, 20);

        // Timeouts with done held low: two retries, then fault.
        exp_q.push_back(8);
        exp_q.push_back(8);
        for (int k = 1; k <= 3; k++) begin
            wait_state(SWaitDone, 60, "to_waitdone");
            count_while(SWaitDone, n);
            check("to_len", n, 100);
            check("to_retry", retry_cnt, k);
            check("to_next", state, (k < 3) ? SPwrup : SFault);
        end
        check("fault_flag", fault, 1);
        check("fault_busy", busy, 0);
        exp_q.push_back(8);
        press_bg();
        wait_state(SWaitLock, 40, "fault_press");
        check("fault_retry_clr", retry_cnt, 0);

        // Asynchronous reset in WAIT_DONE.
        wait_state(SWaitDone, 60, "ar_waitdone");
        tick(10);
        #2;
        rstn = 1'b0;
        #1;
        check("ar_state", state, SIdle);
        check("ar_busy", busy, 0);
        check("ar_start", cam_start, 0);
        check("ar_retry", retry_cnt, 0);
        @(negedge clk);
        rstn = 1'b1;
        tick(20);
        check("ar_idle", state, SIdle);

        check("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cam_boot_seq.md
# cam_boot_seq

Camera boot sequencer in the `i_top_clk` domain, directly upstream of the OV7670 `cam_top` start input. It waits for the clock wizard to lock and applies a camera power-up delay. It then issues a stretched start pulse, waits for the camera's config-done flag, and retries on timeout. It replaces the raw `i_top_cam_start` button with a debounced, sequenced, fault-reporting start.

## Interface
- `DEBOUNCE_CYC`, 240_000: cycles the synchronized button must be stable before a press registers.
- `PWRUP_CYC`, 1_000_000: delay after lock before the first start (10 ms at 100 MHz).
- `START_PULSE_CYC`, 8: `o_cam_start` high time in cycles; must be ≥ 4 so the 25 MHz domain sees it.
- `TIMEOUT_CYC`, 50_000_000: maximum wait for done per attempt.
- `MAX_RETRY`, 3: retries after the first attempt, range 0..3.
- `i_clk`  in  1  `i_top_clk`, 100 MHz.
- `i_rstn`  in  1  reset `w_rst_btn_db`, asynchronous, active-low.
- `i_btn_start`  in  1  raw start button, active-high, asynchronous.
- `i_locked`  in  1  clock wizard `locked`, asynchronous.
- `i_cam_done`  in  1  `cam_top` `o_cam_done` level, asynchronous to `i_clk`.
- `o_cam_start`  out  1  start to `cam_top`.
- `o_busy`  out  1  high in WAIT_LOCK, PWRUP, START, WAIT_DONE.
- `o_ready`  out  1  camera configured.
- `o_fault`  out  1  retries exhausted.
- `o_retry_cnt`  out  2  attempts failed so far.
- `o_state`  out  3  FSM state code, for debug.

## Operation
- Input conditioning:
  - `i_btn_start`, `i_locked` and `i_cam_done` each pass through 2-FF synchronizers.
  - The synchronized button goes through a stable-count debouncer.
  - A press is a one-cycle event on the debounced 0→1 edge.
- FSM states and `o_state` codes: IDLE=0, WAIT_LOCK=1, PWRUP=2, START=3, WAIT_DONE=4, READY=5, FAULT=6.
- **IDLE**: on a press, go to WAIT_LOCK.
- **WAIT_LOCK**: when synchronized lock = 1, load the counter and go to PWRUP.
- **PWRUP**: count `PWRUP_CYC` cycles, then go to START.
- **START**:
  - `o_cam_start` = 1 for exactly `START_PULSE_CYC` cycles, then go to WAIT_DONE.
  - Clear `done_seen_low` on entry.
- **WAIT_DONE**:
  - Set `done_seen_low` whenever synchronized done = 0, in START or WAIT_DONE.
  - Synchronized done = 1 with `done_seen_low` set → READY.
  - `TIMEOUT_CYC` cycles elapsed → increment `o_retry_cnt`.
  - If `o_retry_cnt` (before increment) < `MAX_RETRY`, go to PWRUP; otherwise go to FAULT.
- **READY**:
  - `o_ready` = 1.
  - A press → START, to reconfigure; `o_retry_cnt` cleared.
- **FAULT**:
  - `o_fault` = 1.
  - A press → WAIT_LOCK with `o_retry_cnt` cleared.
- Lock loss: synchronized lock = 0 in PWRUP, START, WAIT_DONE or READY → WAIT_LOCK the next cycle.
  - `o_cam_start` drops immediately.
  - The counter is reset; `o_retry_cnt` is unchanged.
- Simultaneous events: lock loss has priority over done, timeout and press. Done has priority over timeout in the same cycle.
- All outputs are registered.

## Timing
- Reset values: `o_cam_start`=0, `o_busy`=0, `o_ready`=0, `o_fault`=0, `o_retry_cnt`=0, `o_state`=0. Debouncer and synchronizers are cleared to 0.
- Reset assertion is asynchronous. It aborts any state, including mid-pulse, and outputs go to reset values immediately.
- Button edge → press event: 2 (sync) + `DEBOUNCE_CYC` + 1 cycles.
- Lock rise → PWRUP entry: 3 cycles. PWRUP lasts exactly `PWRUP_CYC` cycles.
- `o_cam_start` rises on the first cycle in START and is high for exactly `START_PULSE_CYC` cycles.
- Done rise → `o_ready`=1: 3 cycles.
- Timeout counter:
  - Starts at WAIT_DONE entry.
  - Sized by `$clog2(TIMEOUT_CYC+1)`.
  - Saturation never occurs; the state exits at terminal count.
- Counters are never allowed to wrap.

## Configuration
- `CAM_AUTOBOOT_EN` defined:
  - After reset release, IDLE moves to WAIT_LOCK on the first cycle with no press required.
  - FAULT still requires a press.
- `CAM_AUTOBOOT_EN` not defined: IDLE waits for a debounced press.

## Test plan
Bench parameters: `DEBOUNCE_CYC`=10, `PWRUP_CYC`=20, `START_PULSE_CYC`=8, `TIMEOUT_CYC`=100, `MAX_RETRY`=2.
- **Nominal boot**:
  - Stimulus: lock high, press held 15 cycles, done rises 40 cycles after the start pulse.
  - Response: one 8-cycle `o_cam_start`; `o_ready`=1 3 cycles after the done rise; `o_retry_cnt`=0.
- **Bounce**: press toggled every 5 cycles for 50 cycles, then released → no state change from IDLE.
- **Timeout/retry**:
  - Stimulus: done held 0.
  - Response: 3 start pulses, `o_retry_cnt` 1→2→3, `o_fault`=1; a press then returns to WAIT_LOCK with count 0.
- **Stale done**:
  - Stimulus: done held 1 through START and for 30 cycles, then low 5 cycles, then high.
  - Response: READY only after the second rise.
- **Lock loss mid-pulse**:
  - Stimulus: drop lock at pulse cycle 3.
  - Response: `o_cam_start`=0 within 3 cycles; state WAIT_LOCK; relock → full PWRUP, then a fresh 8-cycle pulse.
- **Async reset** in WAIT_DONE → all outputs 0 immediately. With `CAM_AUTOBOOT_EN` defined, reboot starts without a press.
